// File: rtl/b01_serial_tx.sv
// Word-pair serializer / response collector for the b01 serial-flow FSM.
// Optional build macro B01_TX_MSB_FIRST_EN selects MSB-first bit order (default LSB-first).
module b01_serial_tx #(
    parameter int WIDTH  = 8,
    parameter int RX_LAT = 1,
    parameter int GAP    = 1
) (
    input  logic             clock,
    input  logic             RESET_G,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             LINE1,
    output logic             LINE2,
    input  logic             OUTP_REG,
    input  logic             OVERFLW_REG,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_ovf,
    output logic             result_valid
);

    localparam int CW = $clog2(WIDTH + RX_LAT);
    localparam int GW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DRAIN,
        ST_GAP
    } state_t;

`ifdef B01_TX_MSB_FIRST_EN
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], 1'b0};
    endfunction

    // First response pushed ends up in the MSB after WIDTH pushes.
    function automatic logic [WIDTH-1:0] push(input logic [WIDTH-1:0] acc, input logic b);
        return {acc[WIDTH-2:0], b};
    endfunction
`else
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return {1'b0, w[WIDTH-1:1]};
    endfunction

    // First response pushed ends up in the LSB after WIDTH pushes.
    function automatic logic [WIDTH-1:0] push(input logic [WIDTH-1:0] acc, input logic b);
        return {b, acc[WIDTH-1:1]};
    endfunction
`endif

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [GW-1:0]    gap_cnt_reg, gap_cnt_next;
    logic [WIDTH-1:0] sh_a_reg, sh_a_next;
    logic [WIDTH-1:0] sh_b_reg, sh_b_next;
    logic             line1_reg, line1_next;
    logic             line2_reg, line2_next;
    logic             in_ready_reg, in_ready_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic             ovf_acc_reg, ovf_acc_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             result_ovf_reg, result_ovf_next;
    logic             result_valid_reg, result_valid_next;
    logic             sample;

    always_ff @(posedge clock) begin
        if (RESET_G) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            gap_cnt_reg      <= '0;
            sh_a_reg         <= '0;
            sh_b_reg         <= '0;
            line1_reg        <= 1'b0;
            line2_reg        <= 1'b0;
            in_ready_reg     <= 1'b0;
            acc_reg          <= '0;
            ovf_acc_reg      <= 1'b0;
            result_reg       <= '0;
            result_ovf_reg   <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            gap_cnt_reg      <= gap_cnt_next;
            sh_a_reg         <= sh_a_next;
            sh_b_reg         <= sh_b_next;
            line1_reg        <= line1_next;
            line2_reg        <= line2_next;
            in_ready_reg     <= in_ready_next;
            acc_reg          <= acc_next;
            ovf_acc_reg      <= ovf_acc_next;
            result_reg       <= result_next;
            result_ovf_reg   <= result_ovf_next;
            result_valid_reg <= result_valid_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        gap_cnt_next      = gap_cnt_reg;
        sh_a_next         = sh_a_reg;
        sh_b_next         = sh_b_reg;
        line1_next        = 1'b0;
        line2_next        = 1'b0;
        acc_next          = acc_reg;
        ovf_acc_next      = ovf_acc_reg;
        result_next       = result_reg;
        result_ovf_next   = result_ovf_reg;
        result_valid_next = 1'b0;

        // The counter runs continuously through SHIFT and DRAIN, so the
        // response to bit k arrives exactly when cnt_reg == k + RX_LAT.
        sample = ((state_reg == ST_SHIFT) || (state_reg == ST_DRAIN)) &&
                 (cnt_reg >= CW'(RX_LAT));
        if (sample) begin
            acc_next     = push(acc_reg, OUTP_REG);
            ovf_acc_next = ovf_acc_reg | OVERFLW_REG;
        end

        case (state_reg)
            ST_IDLE: begin
                if (in_valid && in_ready_reg) begin
                    state_next   = ST_SHIFT;
                    cnt_next     = '0;
                    line1_next   = first_bit(in_a);
                    line2_next   = first_bit(in_b);
                    sh_a_next    = advance(in_a);
                    sh_b_next    = advance(in_b);
                    acc_next     = '0;
                    ovf_acc_next = 1'b0;
                end
            end
            ST_SHIFT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next = ST_DRAIN;
                end else begin
                    line1_next = first_bit(sh_a_reg);
                    line2_next = first_bit(sh_b_reg);
                    sh_a_next  = advance(sh_a_reg);
                    sh_b_next  = advance(sh_b_reg);
                end
            end
            ST_DRAIN: begin
                if (cnt_reg == CW'(WIDTH + RX_LAT - 1)) begin
                    result_next       = acc_next;
                    result_ovf_next   = ovf_acc_next;
                    result_valid_next = 1'b1;
                    cnt_next          = '0;
                    gap_cnt_next      = '0;
                    state_next        = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == GW'(GAP - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Registered ready: rises the cycle the FSM lands in IDLE.
        in_ready_next = (state_next == ST_IDLE);
    end

    assign in_ready     = in_ready_reg;
    assign LINE1        = line1_reg;
    assign LINE2        = line2_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign result       = result_reg;
    assign result_ovf   = result_ovf_reg;
    assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_b01_serial_tx.sv
// Scoreboard bench for b01_serial_tx: default instance plus a GAP=0/RX_LAT=3 instance,
// with the partner FSM modelled as XOR/AND of the lines delayed RX_LAT cycles.
module tb_b01_serial_tx;

    localparam int W = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         RESET_G, in_valid, in_ready, LINE1, LINE2, OUTP_REG, OVERFLW_REG;
    logic         busy, result_ovf, result_valid;
    logic [W-1:0] in_a, in_b, result;

    logic         in_valid5, in_ready5, line1_5, line2_5, outp5, ovf5;
    logic         busy5, result_ovf5, result_valid5;
    logic [W-1:0] in_a5, in_b5, result5;

    b01_serial_tx #(.WIDTH(W), .RX_LAT(1), .GAP(1)) dut (
        .clock(clock), .RESET_G(RESET_G), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .LINE1(LINE1), .LINE2(LINE2),
        .OUTP_REG(OUTP_REG), .OVERFLW_REG(OVERFLW_REG), .busy(busy),
        .result(result), .result_ovf(result_ovf), .result_valid(result_valid)
    );

    b01_serial_tx #(.WIDTH(W), .RX_LAT(3), .GAP(0)) dut5 (
        .clock(clock), .RESET_G(RESET_G), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_a(in_a5), .in_b(in_b5), .LINE1(line1_5), .LINE2(line2_5),
        .OUTP_REG(outp5), .OVERFLW_REG(ovf5), .busy(busy5),
        .result(result5), .result_ovf(result_ovf5), .result_valid(result_valid5)
    );

    // Partner model: XOR / AND of the lines through an RX_LAT-deep pipeline.
    logic       px1, pa1;
    logic [2:0] px3, pa3;
    always @(posedge clock) begin
        px1 <= LINE1 ^ LINE2;
        pa1 <= LINE1 & LINE2;
        px3 <= {px3[1:0], line1_5 ^ line2_5};
        pa3 <= {pa3[1:0], line1_5 & line2_5};
    end
    assign OUTP_REG    = px1;
    assign OVERFLW_REG = pa1;
    assign outp5       = px3[2];
    assign ovf5        = pa3[2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = -1;
    logic mon_en = 1'b0;

    typedef struct {
        int           due;
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] exp_line[int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Accept logger: builds the expected line stream and result for each accepted pair.
    exp_t lg_e;
    int   lg_idx;
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (RESET_G) begin
            sb.delete();
            exp_line.delete();
        end else if (in_valid && in_ready) begin
            lg_e.due = cyc + W + 1 + 1;
            lg_e.res = in_a ^ in_b;
            lg_e.ovf = |(in_a & in_b);
            sb.push_back(lg_e);
            last_acc = cyc;
            for (int k = 0; k < W; k++) begin
`ifdef B01_TX_MSB_FIRST_EN
                lg_idx = W - 1 - k;
`else
                lg_idx = k;
`endif
                exp_line[cyc + 1 + k] = {in_b[lg_idx], in_a[lg_idx]};
            end
        end
    end

    // Output monitor for the default instance.
    logic [1:0] mn_el;
    exp_t       mn_e;
    always @(negedge clock) begin
        if (mon_en) begin
            mn_el = exp_line.exists(cyc) ? exp_line[cyc] : 2'b00;
            check("line", {30'd0, LINE2, LINE1}, {30'd0, mn_el});
            if (sb.size() > 0 && sb[0].due < cyc) begin
                check("rv_missing", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            if (result_valid) begin
                if (sb.size() == 0) begin
                    check("rv_unexpected", 32'd1, 32'd0);
                end else begin
                    mn_e = sb.pop_front();
                    $display("result: cycle=%0d result=%02h ovf=%0b", cyc, result, result_ovf);
                    check("rv_cycle", cyc, mn_e.due);
                    check("result", {24'd0, result}, {24'd0, mn_e.res});
                    check("result_ovf", {31'd0, result_ovf}, {31'd0, mn_e.ovf});
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int n;
        n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clock); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, c_acc, rv_c, rd_c, n;
        RESET_G   = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'hAA;
        in_b      = 8'h55;
        in_valid5 = 1'b0;
        in_a5     = '0;
        in_b5     = '0;

        // Reset held three cycles with in_valid high.
        repeat (3) begin
            @(posedge clock); #1;
            mon_en = 1'b1;
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_ready", {31'd0, in_ready}, 32'd0);
            check("rst_result", {24'd0, result}, 32'd0);
            check("rst_rv", {31'd0, result_valid}, 32'd0);
        end
        RESET_G  = 1'b0;
        in_valid = 1'b0;
        check("post_rst_ready0", {31'd0, in_ready}, 32'd0);
        @(posedge clock); #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_ready1", {31'd0, in_ready}, 32'd1);

        // Basic frame: A5/3C -> 99, ovf=1.
        send(8'hA5, 8'h3C, 1'b0);
        wait_idle();

        // Back-to-back with in_valid held high.
        send(8'h01, 8'h00, 1'b1);
        t1 = last_acc;
        send(8'hFF, 8'h00, 1'b0);
        check("accept_spacing", last_acc - t1, 32'd11);
        wait_idle();

        // Reset mid-frame at t+4.
        send(8'hC3, 8'h5A, 1'b0);
        repeat (3) begin @(posedge clock); #1; end
        RESET_G = 1'b1;
        @(posedge clock); #1;
        RESET_G = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_lines", {30'd0, LINE2, LINE1}, 32'd0);
        check("midrst_ready0", {31'd0, in_ready}, 32'd0);
        @(posedge clock); #1;
        check("midrst_ready1", {31'd0, in_ready}, 32'd1);
        send(8'h6E, 8'h3B, 1'b0);
        wait_idle();

        // Single set bit: shows bit order on LINE1.
        send(8'h80, 8'h00, 1'b0);
        wait_idle();

        for (int i = 0; i < 4; i++) begin
            send(W'($urandom), W'($urandom), 1'b0);
            repeat ($urandom_range(0, 12)) @(posedge clock);
            #1;
        end
        wait_idle();
        check("sb_empty", sb.size(), 32'd0);

        // GAP=0 / RX_LAT=3 instance: result and next accept both at t+12.
        in_a5 = 8'h5A;
        in_b5 = 8'hC3;
        in_valid5 = 1'b1;
        n = 0;
        while (in_ready5 !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
        if (n >= 20) check("g0_ready_timeout", 32'd1, 32'd0);
        c_acc = cyc;
        @(posedge clock); #1;
        in_a5 = 8'h0F;
        in_b5 = 8'h01;
        rv_c = -1;
        rd_c = -1;
        n = 0;
        while ((rv_c < 0 || rd_c < 0) && n < 40) begin
            if (result_valid5 && rv_c < 0) begin
                rv_c = cyc;
                $display("result5: cycle=%0d result=%02h ovf=%0b", cyc, result5, result_ovf5);
                check("g0_result1", {24'd0, result5}, 32'h99);
                check("g0_ovf1", {31'd0, result_ovf5}, 32'd1);
            end
            if (in_ready5 && rd_c < 0) rd_c = cyc;
            if (rv_c < 0 || rd_c < 0) begin @(posedge clock); #1; end
            n++;
        end
        check("g0_rv_cycle", rv_c - c_acc, 32'd12);
        check("g0_accept_cycle", rd_c - c_acc, 32'd12);
        @(posedge clock); #1;
        in_valid5 = 1'b0;
        n = 0;
        while (result_valid5 !== 1'b1 && n < 40) begin @(posedge clock); #1; n++; end
        $display("result5: cycle=%0d result=%02h ovf=%0b", cyc, result5, result_ovf5);
        check("g0_rv2_cycle", cyc - rd_c, 32'd12);
        check("g0_result2", {24'd0, result5}, 32'h0E);
        check("g0_ovf2", {31'd0, result_ovf5}, 32'd1);

        repeat (3) @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
